// File: rtl/m2_idct_block_scheduler.sv
// Mega-state sequencer for the Milestone 2 IDCT path: walks every 8x8 block of Y, U, V and
// starts the FS/CT/CS/WS engines. Defining M2_SCHED_PERF_EN adds a saturating cycle counter.
module m2_idct_block_scheduler #(
  parameter int Y_BLOCK_COLS  = 40,
  parameter int UV_BLOCK_COLS = 20,
  parameter int BLOCK_ROWS    = 30,
  parameter int PRE_IDCT_BASE = 76800,
  parameter int U_BASE        = 38400,
  parameter int V_BASE        = 57600
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  output logic        Done,
  output logic        fs_start,
  output logic        ct_start,
  output logic        cs_start,
  output logic        ws_start,
  input  logic        fs_done,
  input  logic        ct_done,
  input  logic        cs_done,
  input  logic        ws_done,
  output logic [17:0] fs_base_addr,
  output logic [17:0] fs_row_stride,
  output logic [17:0] ws_base_addr,
  output logic [17:0] ws_row_stride,
  output logic [1:0]  sram_owner,
  output logic [31:0] cycle_count
);

  localparam int N  = (Y_BLOCK_COLS + 2 * UV_BLOCK_COLS) * BLOCK_ROWS;
  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(Y_BLOCK_COLS + 1);
  localparam int RW = $clog2(BLOCK_ROWS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [2:0] {IDLE, LI_FS, MS_B, MS_A, LO_WS, FINISH} state_t;

  typedef struct packed {
    logic [1:0]    plane;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
  } pos_t;

  state_t        state_reg;
  logic [KW-1:0] k_reg;
  pos_t          fs_pos_reg, ws_pos_reg;
  logic [3:0]    done_vec, start_vec, act_vec, flag_vec;
  logic          all_set, advance;

  function automatic pos_t next_pos(input pos_t p);
    pos_t n;
    int   cols;
    n    = p;
    cols = (p.plane == 2'd0) ? Y_BLOCK_COLS : UV_BLOCK_COLS;
    if (int'(p.c) == cols - 1) begin
      n.c = '0;
      if (int'(p.r) == BLOCK_ROWS - 1) begin
        n.r     = '0;
        n.plane = p.plane + 2'd1;
      end else begin
        n.r = p.r + RW'(1);
      end
    end else begin
      n.c = p.c + CW'(1);
    end
    return n;
  endfunction

  // S' rows are 8 coefficients per block column; output rows hold 2 pixels per word.
  function automatic logic [17:0] fs_addr(input pos_t p);
    logic [17:0] r18, c18, a;
    r18 = 18'(p.r);
    c18 = 18'(p.c);
    case (p.plane)
      2'd0:    a = 18'(PRE_IDCT_BASE) + r18 * 18'd2560 + (c18 << 3);
      2'd1:    a = 18'(PRE_IDCT_BASE + 76800) + r18 * 18'd1280 + (c18 << 3);
      default: a = 18'(PRE_IDCT_BASE + 115200) + r18 * 18'd1280 + (c18 << 3);
    endcase
    return a;
  endfunction

  function automatic logic [17:0] ws_addr(input pos_t p);
    logic [17:0] r18, c18, a;
    r18 = 18'(p.r);
    c18 = 18'(p.c);
    case (p.plane)
      2'd0:    a = r18 * 18'd1280 + (c18 << 2);
      2'd1:    a = 18'(U_BASE) + r18 * 18'd640 + (c18 << 2);
      default: a = 18'(V_BASE) + r18 * 18'd640 + (c18 << 2);
    endcase
    return a;
  endfunction

  assign done_vec  = {ws_done, cs_done, ct_done, fs_done};
  assign start_vec = {ws_start, cs_start, ct_start, fs_start};

  always_comb begin
    act_vec[0] = (state_reg == LI_FS) || (state_reg == MS_A && k_reg != K_LAST);
    act_vec[1] = (state_reg == MS_B);
    act_vec[2] = (state_reg == MS_A);
    act_vec[3] = (state_reg == LO_WS) || (state_reg == MS_B && k_reg != '0);
    all_set    = &(flag_vec | ~act_vec);
    advance    = all_set && (state_reg inside {LI_FS, MS_B, MS_A, LO_WS});
  end

  // A done coinciding with its own start pulse belongs to no job yet, so it is dropped.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      logic flag_reg;
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
          flag_reg <= 1'b0;
        else if (advance)
          flag_reg <= 1'b0;
        else if (done_vec[gi] && act_vec[gi] && !start_vec[gi])
          flag_reg <= 1'b1;
      end
      assign flag_vec[gi] = flag_reg;
    end
  endgenerate

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      fs_pos_reg    <= '0;
      ws_pos_reg    <= '0;
      Done          <= 1'b0;
      fs_start      <= 1'b0;
      ct_start      <= 1'b0;
      cs_start      <= 1'b0;
      ws_start      <= 1'b0;
      fs_base_addr  <= '0;
      fs_row_stride <= '0;
      ws_base_addr  <= '0;
      ws_row_stride <= '0;
      sram_owner    <= 2'b00;
    end else begin
      Done     <= 1'b0;
      fs_start <= 1'b0;
      ct_start <= 1'b0;
      cs_start <= 1'b0;
      ws_start <= 1'b0;
      case (state_reg)
        IDLE: if (Enable) begin
          state_reg     <= LI_FS;
          k_reg         <= '0;
          fs_start      <= 1'b1;
          fs_base_addr  <= fs_addr('0);
          fs_row_stride <= 18'd320;
          fs_pos_reg    <= next_pos('0);
          ws_pos_reg    <= '0;
          sram_owner    <= 2'b01;
        end
        LI_FS: if (advance) begin
          state_reg  <= MS_B;
          ct_start   <= 1'b1;
          sram_owner <= 2'b00;
        end
        MS_B: if (advance) begin
          state_reg <= MS_A;
          cs_start  <= 1'b1;
          if (k_reg != K_LAST) begin
            fs_start      <= 1'b1;
            fs_base_addr  <= fs_addr(fs_pos_reg);
            fs_row_stride <= (fs_pos_reg.plane == 2'd0) ? 18'd320 : 18'd160;
            fs_pos_reg    <= next_pos(fs_pos_reg);
            sram_owner    <= 2'b01;
          end else begin
            sram_owner <= 2'b00;
          end
        end
        MS_A: if (advance) begin
          // Both successors start WS on the block whose CS just finished.
          ws_start      <= 1'b1;
          ws_base_addr  <= ws_addr(ws_pos_reg);
          ws_row_stride <= (ws_pos_reg.plane == 2'd0) ? 18'd160 : 18'd80;
          ws_pos_reg    <= next_pos(ws_pos_reg);
          sram_owner    <= 2'b10;
          if (k_reg != K_LAST) begin
            k_reg     <= k_reg + KW'(1);
            state_reg <= MS_B;
            ct_start  <= 1'b1;
          end else begin
            state_reg <= LO_WS;
          end
        end
        LO_WS: if (advance) begin
          state_reg  <= FINISH;
          Done       <= 1'b1;
          sram_owner <= 2'b00;
        end
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef M2_SCHED_PERF_EN
  logic [31:0] cycle_count_reg;
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      cycle_count_reg <= '0;
    else if (state_reg == IDLE) begin
      if (Enable)
        cycle_count_reg <= '0;
    end else if (cycle_count_reg != 32'hFFFF_FFFF)
      cycle_count_reg <= cycle_count_reg + 32'd1;
  end
  assign cycle_count = cycle_count_reg;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_m2_idct_block_scheduler.sv
// Bench for m2_idct_block_scheduler: random engine latencies checked against a block-order
// reference model, plus directed done-tracking, reset and tiny-plane sequence scenarios.
module tb_m2_idct_block_scheduler;
  localparam int YC = 40, UVC = 20, BR = 30;
  localparam int N  = (YC + 2 * UVC) * BR;

  logic        Clock, Resetn, Enable;
  logic        Done, fs_start, ct_start, cs_start, ws_start;
  logic        fs_done, ct_done, cs_done, ws_done;
  logic [17:0] fs_base_addr, fs_row_stride, ws_base_addr, ws_row_stride;
  logic [1:0]  sram_owner;
  logic [31:0] cycle_count;
  logic [3:0]  done_v;
  wire  [3:0]  st = {ws_start, cs_start, ct_start, fs_start};
  assign {ws_done, cs_done, ct_done, fs_done} = done_v;

  logic        s_enable, s_done_o, s_fs_start, s_ct_start, s_cs_start, s_ws_start;
  logic [3:0]  s_done_v;
  logic [17:0] s_fs_addr, s_fs_stride, s_ws_addr, s_ws_stride;
  logic [1:0]  s_owner;
  logic [31:0] s_cycles;
  wire  [3:0]  s_st = {s_ws_start, s_cs_start, s_ct_start, s_fs_start};

  int  n_asrt, n_fail;
  int  cnt[4];
  bit  spurious_en;

  m2_idct_block_scheduler dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Done(Done),
    .fs_start(fs_start), .ct_start(ct_start), .cs_start(cs_start), .ws_start(ws_start),
    .fs_done(fs_done), .ct_done(ct_done), .cs_done(cs_done), .ws_done(ws_done),
    .fs_base_addr(fs_base_addr), .fs_row_stride(fs_row_stride),
    .ws_base_addr(ws_base_addr), .ws_row_stride(ws_row_stride),
    .sram_owner(sram_owner), .cycle_count(cycle_count)
  );

  m2_idct_block_scheduler #(.Y_BLOCK_COLS(1), .UV_BLOCK_COLS(1), .BLOCK_ROWS(1)) dut_tiny (
    .Clock(Clock), .Resetn(Resetn), .Enable(s_enable), .Done(s_done_o),
    .fs_start(s_fs_start), .ct_start(s_ct_start), .cs_start(s_cs_start), .ws_start(s_ws_start),
    .fs_done(s_done_v[0]), .ct_done(s_done_v[1]), .cs_done(s_done_v[2]), .ws_done(s_done_v[3]),
    .fs_base_addr(s_fs_addr), .fs_row_stride(s_fs_stride),
    .ws_base_addr(s_ws_addr), .ws_row_stride(s_ws_stride),
    .sram_owner(s_owner), .cycle_count(s_cycles)
  );

  always #5 Clock = ~Clock;

  // Reference: block index -> (plane, row, col) -> SRAM address, straight from the image layout.
  function automatic int ref_addr(input int b, input bit ws);
    int p, r, c, i;
    if (b < YC * BR) begin
      p = 0; r = b / YC; c = b % YC;
    end else begin
      i = b - YC * BR;
      p = 1 + i / (UVC * BR);
      i = i % (UVC * BR);
      r = i / UVC; c = i % UVC;
    end
    if (ws) return (p == 0) ? r * 1280 + c * 4 : ((p == 1) ? 38400 : 57600) + r * 640 + c * 4;
    return (p == 0) ? 76800 + r * 2560 + c * 8 : ((p == 1) ? 153600 : 192000) + r * 1280 + c * 8;
  endfunction

  function automatic int ref_stride(input int b, input bit ws);
    if (b < YC * BR) return ws ? 160 : 320;
    return ws ? 80 : 160;
  endfunction

  // Engine model: each start is acknowledged after a random 1..4 cycles; idle engines may glitch.
  task automatic engine_step();
    for (int e = 0; e < 4; e++) begin
      if (st[e]) begin
        cnt[e]    = $urandom_range(1, 4);
        done_v[e] = 1'b0;
      end else if (cnt[e] > 0) begin
        cnt[e]    = cnt[e] - 1;
        done_v[e] = (cnt[e] == 0);
      end else begin
        done_v[e] = spurious_en && ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  task automatic wait_start(input int idx, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (st[idx]) begin
        found = 1'b1;
        break;
      end
      @(negedge Clock);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0; Enable = 1'b0; done_v = '0;
    for (int e = 0; e < 4; e++) cnt[e] = 0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Enable = 1'b0; done_v = '0; s_enable = 1'b0; s_done_v = '0;
    repeat (3) @(negedge Clock);
    n_asrt++;
    if ({Done, st, fs_base_addr, fs_row_stride, ws_base_addr, ws_row_stride, sram_owner, cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got start=%b addr=%0d/%0d owner=%b, required all zero", st, fs_base_addr, ws_base_addr, sram_owner);
    end
    Resetn = 1'b1;
    repeat (3) @(negedge Clock);
    n_asrt++;
    if ({Done, st, sram_owner, cycle_count} !== '0) begin
      n_fail++;
      $display("FAIL idle_quiet: got done=%b start=%b owner=%b, required all zero", Done, st, sram_owner);
    end
  endtask

  task automatic test_done_tracking();
    int ct_q[$], cs_q[$];
    bit found;
    do_reset();
    spurious_en = 1'b0;
    Enable = 1'b1; @(negedge Clock); Enable = 1'b0;
    n_asrt++;
    if (fs_start !== 1'b1 || sram_owner !== 2'b01 || fs_base_addr !== 18'd76800) begin
      n_fail++;
      $display("FAIL li_fs_entry: got fs_start=%b owner=%b addr=%0d, required 1 01 76800", fs_start, sram_owner, fs_base_addr);
    end
    @(negedge Clock); done_v = 4'b0001;
    @(negedge Clock); done_v = 4'b0000;
    wait_start(1, 10, found);
    n_asrt++;
    if (!found || ws_start !== 1'b0 || sram_owner !== 2'b00) begin
      n_fail++;
      $display("FAIL first_ms_b: got found=%0b ws_start=%b owner=%b, required 1 0 00", found, ws_start, sram_owner);
    end
    @(negedge Clock); done_v = 4'b0010;
    @(negedge Clock); done_v = 4'b0000;
    wait_start(2, 10, found);
    n_asrt++;
    if (!found || fs_start !== 1'b1 || fs_base_addr !== 18'd76808 || fs_row_stride !== 18'd320 || sram_owner !== 2'b01) begin
      n_fail++;
      $display("FAIL ms_a0_entry: got found=%0b fs_start=%b addr=%0d stride=%0d owner=%b, required 1 1 76808 320 01",
               found, fs_start, fs_base_addr, fs_row_stride, sram_owner);
    end
    for (int t = 0; t <= 56; t++) begin
      if (ct_start) ct_q.push_back(t);
      if (cs_start) cs_q.push_back(t);
      if (t == 41) begin
        n_asrt++;
        if (sram_owner !== 2'b01) begin
          n_fail++;
          $display("FAIL owner_ms_a_late: got %b, required 01", sram_owner);
        end
      end
      if (t == 42) begin
        n_asrt++;
        if (ws_start !== 1'b1 || ws_base_addr !== 18'd0 || ws_row_stride !== 18'd160 || sram_owner !== 2'b10) begin
          n_fail++;
          $display("FAIL ws_block0: got start=%b addr=%0d stride=%0d owner=%b, required 1 0 160 10",
                   ws_start, ws_base_addr, ws_row_stride, sram_owner);
        end
      end
      if (t == 46) begin
        n_asrt++;
        if (fs_start !== 1'b1 || fs_base_addr !== 18'd76816) begin
          n_fail++;
          $display("FAIL fs_block2: got start=%b addr=%0d, required 1 76816", fs_start, fs_base_addr);
        end
      end
      done_v = 4'b0000;
      case (t)
        5:  done_v = 4'b0100;
        10: done_v = 4'b1000;
        40: done_v = 4'b0001;
        44: done_v = 4'b1010;
        46: done_v = 4'b0101;
        52: done_v = 4'b0101;
        default: done_v = 4'b0000;
      endcase
      @(negedge Clock);
    end
    done_v = 4'b0000;
    n_asrt++;
    if (ct_q.size() != 2 || ct_q[0] != 42 || ct_q[1] != 54) begin
      n_fail++;
      $display("FAIL exit_timing_ct: got %0d pulses first=%0d second=%0d, required 2 at 42 and 54",
               ct_q.size(), ct_q.size() > 0 ? ct_q[0] : -1, ct_q.size() > 1 ? ct_q[1] : -1);
    end
    n_asrt++;
    if (cs_q.size() != 2 || cs_q[0] != 0 || cs_q[1] != 46) begin
      n_fail++;
      $display("FAIL exit_timing_cs: got %0d pulses first=%0d second=%0d, required 2 at 0 and 46",
               cs_q.size(), cs_q.size() > 0 ? cs_q[0] : -1, cs_q.size() > 1 ? cs_q[1] : -1);
    end
  endtask

  task automatic test_full_run();
    int fs_n, ct_n, cs_n, ws_n, done_n, done_cyc;
    bit fs_busy, ws_busy, timed_out;
    longint exp_cnt;
    do_reset();
    spurious_en = 1'b1;
    fs_n = 0; ct_n = 0; cs_n = 0; ws_n = 0; done_n = 0; done_cyc = -1; timed_out = 1'b1;
    Enable = 1'b1; @(negedge Clock); Enable = 1'b0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      Enable  = (cyc == 100);
      fs_busy = fs_start || cnt[0] > 0;
      ws_busy = ws_start || cnt[3] > 0;
      n_asrt++;
      if ((fs_busy && sram_owner == 2'b10) || (ws_busy && sram_owner == 2'b01)) begin
        n_fail++;
        $display("FAIL sram_owner cycle %0d: got %b with fs_busy=%0b ws_busy=%0b", cyc, sram_owner, fs_busy, ws_busy);
      end
      if (fs_start) begin
        n_asrt++;
        if (fs_base_addr !== 18'(ref_addr(fs_n, 1'b0)) || fs_row_stride !== 18'(ref_stride(fs_n, 1'b0))) begin
          n_fail++;
          $display("FAIL fs_addr block %0d: got %0d stride %0d, required %0d stride %0d",
                   fs_n, fs_base_addr, fs_row_stride, ref_addr(fs_n, 1'b0), ref_stride(fs_n, 1'b0));
        end
        fs_n++;
      end
      if (ws_start) begin
        n_asrt++;
        if (ws_base_addr !== 18'(ref_addr(ws_n, 1'b1)) || ws_row_stride !== 18'(ref_stride(ws_n, 1'b1))) begin
          n_fail++;
          $display("FAIL ws_addr block %0d: got %0d stride %0d, required %0d stride %0d",
                   ws_n, ws_base_addr, ws_row_stride, ref_addr(ws_n, 1'b1), ref_stride(ws_n, 1'b1));
        end
        ws_n++;
      end
      if (ct_start) ct_n++;
      if (cs_start) cs_n++;
      if (Done) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
`ifdef M2_SCHED_PERF_EN
          exp_cnt = cyc;
`else
          exp_cnt = 0;
`endif
          n_asrt++;
          if (cycle_count !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL cycle_count_at_done: got %0d, required %0d", cycle_count, exp_cnt);
          end
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 5) begin
        timed_out = 1'b0;
`ifdef M2_SCHED_PERF_EN
        exp_cnt = done_cyc + 1;
`else
        exp_cnt = 0;
`endif
        n_asrt++;
        if (cycle_count !== 32'(exp_cnt)) begin
          n_fail++;
          $display("FAIL cycle_count_hold: got %0d, required %0d", cycle_count, exp_cnt);
        end
        break;
      end
      engine_step();
      @(negedge Clock);
    end
    done_v = '0;
    Enable = 1'b0;
    spurious_en = 1'b0;
    n_asrt++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL full_run_timeout: no Done within budget, fs=%0d ws=%0d", fs_n, ws_n);
    end
    n_asrt++;
    if (fs_n != N || ct_n != N || cs_n != N || ws_n != N) begin
      n_fail++;
      $display("FAIL pulse_counts: got fs=%0d ct=%0d cs=%0d ws=%0d, required %0d each", fs_n, ct_n, cs_n, ws_n, N);
    end
    n_asrt++;
    if (done_n != 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d, required 1", done_n);
    end
  endtask

  task automatic test_reset_mid();
    int ct_seen;
    bit hit, done_seen;
    do_reset();
    spurious_en = 1'b0;
    ct_seen = 0; hit = 1'b0; done_seen = 1'b0;
    Enable = 1'b1; @(negedge Clock); Enable = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (Done) done_seen = 1'b1;
      if (ct_start) ct_seen++;
      if (ct_seen == 3) begin
        hit = 1'b1;
        break;
      end
      engine_step();
      @(negedge Clock);
    end
    n_asrt++;
    if (!hit || ws_start !== 1'b1 || sram_owner !== 2'b10) begin
      n_fail++;
      $display("FAIL reach_ms_b2: got hit=%0b ws_start=%b owner=%b, required 1 1 10", hit, ws_start, sram_owner);
    end
    #2 Resetn = 1'b0;
    #1;
    n_asrt++;
    if ({Done, st, fs_base_addr, fs_row_stride, ws_base_addr, ws_row_stride, sram_owner, cycle_count} !== '0 || done_seen) begin
      n_fail++;
      $display("FAIL async_reset: got start=%b fs=%0d ws=%0d owner=%b done_seen=%0b, required all zero",
               st, fs_base_addr, ws_base_addr, sram_owner, done_seen);
    end
    done_v = '0;
    for (int e = 0; e < 4; e++) cnt[e] = 0;
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    n_asrt++;
    if (st !== 4'b0000 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got start=%b done=%b, required 0000 0", st, Done);
    end
    Enable = 1'b1; @(negedge Clock); Enable = 1'b0;
    n_asrt++;
    if (fs_start !== 1'b1 || fs_base_addr !== 18'd76800 || fs_row_stride !== 18'd320) begin
      n_fail++;
      $display("FAIL restart_block0: got start=%b addr=%0d stride=%0d, required 1 76800 320", fs_start, fs_base_addr, fs_row_stride);
    end
    do_reset();
  endtask

  task automatic test_tiny_sequence();
    logic [3:0] exp_q[$], got_q[$];
    logic [1:0] own_q[$], exp_own;
    logic [3:0] prev;
    int done_n, done_at, last_start;
    bit fin;
    exp_q.push_back(4'b0001);
    for (int kk = 0; kk < 3; kk++) begin
      exp_q.push_back(kk > 0 ? 4'b1010 : 4'b0010);
      exp_q.push_back(kk + 1 < 3 ? 4'b0101 : 4'b0100);
    end
    exp_q.push_back(4'b1000);
    prev = '0; done_n = 0; done_at = 0; last_start = 0; fin = 1'b0;
    s_enable = 1'b1; @(negedge Clock); s_enable = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (s_st != 4'b0000) begin
        got_q.push_back(s_st);
        own_q.push_back(s_owner);
        last_start = t;
      end
      if (s_done_o) begin
        done_n++;
        done_at = t;
      end
      if (done_n > 0 && t == done_at + 3) begin
        fin = 1'b1;
        break;
      end
      s_done_v = prev;
      prev = s_st;
      @(negedge Clock);
    end
    s_done_v = '0;
    n_asrt++;
    if (!fin || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL tiny_length: got finished=%0b mega-states=%0d, required 1 %0d", fin, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      exp_own = exp_q[i][0] ? 2'b01 : (exp_q[i][3] ? 2'b10 : 2'b00);
      n_asrt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || own_q[i] !== exp_own) begin
        n_fail++;
        $display("FAIL tiny_megastate %0d: got starts=%b owner=%b, required starts=%b owner=%b",
                 i, i < got_q.size() ? got_q[i] : 4'bxxxx, i < own_q.size() ? own_q[i] : 2'bxx, exp_q[i], exp_own);
      end
    end
    n_asrt++;
    if (done_n != 1 || done_at <= last_start) begin
      n_fail++;
      $display("FAIL tiny_done: got %0d pulses at %0d (last start %0d), required 1 after last start", done_n, done_at, last_start);
    end
  endtask

  initial begin
    Clock = 1'b0; Resetn = 1'b0; Enable = 1'b0; done_v = '0;
    s_enable = 1'b0; s_done_v = '0;
    n_asrt = 0; n_fail = 0; spurious_en = 1'b0;
    for (int e = 0; e < 4; e++) cnt[e] = 0;
    test_reset();
    test_done_tracking();
    test_full_run();
    test_reset_mid();
    test_tiny_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/m2_idct_block_scheduler.md
Name: m2_idct_block_scheduler

Overview:
Top-level sequencer for the Milestone 2 IDCT path. It walks every 8x8 block of the Y, U and V planes and issues start pulses to four engines:
- FS: fetch S' from SRAM into DP-RAM0.
- CT: compute T = S'·C.
- CS: compute S = T·C^T.
- WS: write S to SRAM.

Engines run in overlapped mega-states so the single SRAM port is never claimed by FS and WS at once. The block also supplies per-block SRAM base addresses and row strides to FS and WS, and drives the SRAM owner select.

Parameters:
- Y_BLOCK_COLS, 40, blocks per Y row (320 px / 8).
- UV_BLOCK_COLS, 20, blocks per U/V row (160 px / 8).
- BLOCK_ROWS, 30, block rows per plane (240 px / 8).
- PRE_IDCT_BASE, 76800, SRAM address of the first S' coefficient.
- U_BASE, 38400, SRAM word address of U output.
- V_BASE, 57600, SRAM word address of V output.

Ports:
- Clock  in  1  system clock
- Resetn  in  1  async active-low reset
- Enable  in  1  start pulse; ignored unless state is IDLE
- Done  out  1  one-cycle pulse after the last WS completes
- fs_start, ct_start, cs_start, ws_start  out  1 each  one-cycle engine start pulses
- fs_done, ct_done, cs_done, ws_done  in  1 each  one-cycle engine completion pulses
- fs_base_addr  out  18  SRAM address of S' block row 0, col 0
- fs_row_stride  out  18  320 for Y, 160 for U/V
- ws_base_addr  out  18  SRAM word address of output block row 0
- ws_row_stride  out  18  160 for Y, 80 for U/V
- sram_owner  out  2  00 none, 01 FS, 10 WS
- cycle_count  out  32  performance counter (see Optional Feature)

Behaviour:
- Interface: clock Clock; reset Resetn, asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; all block counters 0.
- Block order: Y raster (row-major), then U, then V. N = (Y_BLOCK_COLS + 2·UV_BLOCK_COLS)·BLOCK_ROWS, which is 2400 by default.
- FS address, Y: PRE_IDCT_BASE + r·2560 + c·8.
- FS address, U: PRE_IDCT_BASE + 76800 + r·1280 + c·8.
- FS address, V: PRE_IDCT_BASE + 115200 + r·1280 + c·8.
- WS address, Y: r·1280 + c·4.
- WS address, U: U_BASE + r·640 + c·4.
- WS address, V: V_BASE + r·640 + c·4.
- Counters: FS and WS each keep an independent (plane, r, c) counter. Each advances in the cycle its start pulse is issued. The base and stride outputs are registered and valid from the start pulse until that engine's done.
- States and transitions:
  - IDLE → LI_FS on Enable.
  - LI_FS: FS(0) runs. Exit → MS_B with k = 0.
  - MS_B: CT(k) runs, plus WS(k-1) when k > 0.
  - MS_A: CS(k) runs, plus FS(k+1) when k+1 < N.
  - From MS_A: if k+1 < N, then k++ and → MS_B; otherwise → LO_WS.
  - LO_WS: WS(N-1) runs. Exit → FINISH.
  - FINISH: Done = 1 for one cycle, then → IDLE.
- Start pulses: every start pulse fires in the first cycle of its mega-state.
- Done tracking: each engine's done pulse sets a sticky flag, and only while that engine is active in the current mega-state. Done pulses from an idle engine are ignored. Simultaneous done pulses are legal. A done pulse in the same cycle as that engine's start is ignored.
- Mega-state exit: exit occurs in the cycle after all active flags are set. Flags clear on entry to the next mega-state. There is no minimum duration.
- sram_owner: 01 throughout LI_FS, and throughout MS_A when FS is active. 10 throughout MS_B when WS is active, and throughout LO_WS. 00 otherwise.
- Enable while busy: no effect.
- Reset mid-operation: immediate return to IDLE; counters cleared; no Done pulse.
- Counter wrap: c wraps to 0 at the plane's column count and r increments. r wraps at BLOCK_ROWS and the plane increments (Y → U → V).

Optional Feature:
- Macro: M2_SCHED_PERF_EN.
- Defined: cycle_count clears on Enable and increments every cycle outside IDLE, up to and including FINISH. It saturates at 0xFFFFFFFF and holds its value in IDLE.
- Not defined: cycle_count is constant 0 and no counter is synthesized.

Test Plan:
- Defaults; Enable; engine model acks each start after 3 cycles → exactly 2400 pulses on each of fs_start, ct_start, cs_start and ws_start, then one Done. sram_owner is never 01 while WS is busy, nor 10 while FS is busy.
- FS block 1 → fs_base_addr 76808, fs_row_stride 320. WS block 1 → ws_base_addr 4, stride 160. Block 1199 → FS 151352, WS 37276.
- Block 1200 (first U) → FS 153600 stride 160, WS 38400 stride 80. Block 1220 (U r1 c0) → FS 154880, WS 39040. Block 1800 (first V) → FS 192000, WS 57600.
- In MS_A, cs_done at cycle 5 and fs_done at cycle 40 → exit cycle 41. Both done in the same cycle → exit the next cycle. A spurious ws_done during MS_A → no effect.
- Y_BLOCK_COLS=1, UV_BLOCK_COLS=1, BLOCK_ROWS=1 (N=3) → state sequence LI_FS, MS_B, MS_A, MS_B, MS_A, MS_B, MS_A, LO_WS, FINISH. The first MS_B has no ws_start; the last MS_A has no fs_start.
- Resetn low mid-MS_B → all outputs 0 and state IDLE; a new Enable restarts at block 0 (fs_base_addr 76800). With M2_SCHED_PERF_EN and 1-cycle acks, cycle_count is nonzero at Done and then stable.
